// File: rtl/mfp_ahb_master_arbiter_pkg.sv
// Shared types and encodings for the two-master AHB-Lite arbiter.
// An address phase is carried as one packed struct so it can be held and muxed as a unit.
package mfp_ahb_master_arbiter_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic MST_CPU = 1'b0;
  localparam logic MST_LDR = 1'b1;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StHeld = 2'd1,
    StData = 2'd2
  } stage_state_e;

  typedef struct packed {
    logic [31:0] haddr;
    logic [2:0]  hburst;
    logic [3:0]  hprot;
    logic [2:0]  hsize;
    logic [1:0]  htrans;
    logic        hmastlock;
    logic        hwrite;
  } addr_phase_t;

  // The current owner may not be pre-empted while it continues a burst or holds the lock.
  function automatic logic keeps_grant(addr_phase_t ap);
    return (ap.htrans == HTRANS_SEQ) || (ap.htrans == HTRANS_BUSY) || ap.hmastlock;
  endfunction

endpackage

// File: rtl/mfp_ahb_input_stage.sv
// Per-master input stage: one-deep hold register plus IDLE/HELD/DATA tracking.
// Presents either the held or the live address phase as this master's arbitration candidate.
module mfp_ahb_input_stage
  import mfp_ahb_master_arbiter_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  addr_phase_t live_i,
  input  logic        s_hready_i,
  input  logic        s_hresp_i,
  input  logic        issue_i,
  output logic        cand_valid_o,
  output addr_phase_t cand_o,
  output logic        hready_o,
  output logic        hresp_o
);

  stage_state_e state_q;
  addr_phase_t  hold_q;
  logic         accept;

  always_comb begin
    hready_o     = (state_q == StIdle) || ((state_q == StData) && s_hready_i);
    hresp_o      = (state_q == StData) ? s_hresp_i : 1'b0;
    accept       = hready_o &&
                   ((live_i.htrans == HTRANS_NONSEQ) || (live_i.htrans == HTRANS_SEQ));
    // BUSY from a live master competes for the bus but never creates a data phase.
    cand_valid_o = (state_q == StHeld) || (hready_o && (live_i.htrans != HTRANS_IDLE));
    cand_o       = (state_q == StHeld) ? hold_q : live_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      hold_q  <= '0;
    end else if (issue_i) begin
      state_q <= StData;
    end else if (state_q == StHeld) begin
      state_q <= StHeld;
    end else if (accept) begin
      state_q <= StHeld;
      hold_q  <= live_i;
    end else if ((state_q == StData) && s_hready_i) begin
      state_q <= StIdle;
    end
  end

endmodule

// File: rtl/mfp_ahb_master_arbiter.sv
// Two-master AHB-Lite arbiter sharing one slave bus between the CPU and the SREC loader.
// Grants move only at transfer boundaries; losers are stalled through their own HREADY.
module mfp_ahb_master_arbiter
  import mfp_ahb_master_arbiter_pkg::*;
#(
  parameter bit LDR_PRIORITY = 1'b1
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic [31:0] cpu_HADDR,
  input  logic [2:0]  cpu_HBURST,
  input  logic [3:0]  cpu_HPROT,
  input  logic [2:0]  cpu_HSIZE,
  input  logic [1:0]  cpu_HTRANS,
  input  logic        cpu_HMASTLOCK,
  input  logic        cpu_HWRITE,
  input  logic [31:0] cpu_HWDATA,
  output logic        cpu_HREADY,
  output logic        cpu_HRESP,
  input  logic [31:0] ldr_HADDR,
  input  logic [2:0]  ldr_HBURST,
  input  logic [3:0]  ldr_HPROT,
  input  logic [2:0]  ldr_HSIZE,
  input  logic [1:0]  ldr_HTRANS,
  input  logic        ldr_HMASTLOCK,
  input  logic        ldr_HWRITE,
  input  logic [31:0] ldr_HWDATA,
  output logic        ldr_HREADY,
  output logic        ldr_HRESP,
  output logic [31:0] s_HADDR,
  output logic [2:0]  s_HBURST,
  output logic [3:0]  s_HPROT,
  output logic [2:0]  s_HSIZE,
  output logic [1:0]  s_HTRANS,
  output logic        s_HMASTLOCK,
  output logic        s_HWRITE,
  output logic [31:0] s_HWDATA,
  input  logic        s_HREADY,
  input  logic        s_HRESP,
  output logic        grant_ldr
);

  addr_phase_t cpu_live, ldr_live, cpu_cand, ldr_cand, win;
  logic        cpu_cv, ldr_cv, any_cand, win_ldr, xfer, cpu_issue, ldr_issue;
  logic        last_owner_q, dphase_vld_q, dphase_owner_q;

  assign cpu_live = '{haddr: cpu_HADDR, hburst: cpu_HBURST, hprot: cpu_HPROT, hsize: cpu_HSIZE,
                      htrans: cpu_HTRANS, hmastlock: cpu_HMASTLOCK, hwrite: cpu_HWRITE};
  assign ldr_live = '{haddr: ldr_HADDR, hburst: ldr_HBURST, hprot: ldr_HPROT, hsize: ldr_HSIZE,
                      htrans: ldr_HTRANS, hmastlock: ldr_HMASTLOCK, hwrite: ldr_HWRITE};

  mfp_ahb_input_stage u_cpu_stage (
    .clk_i        (HCLK),
    .rst_i        (HRESET),
    .live_i       (cpu_live),
    .s_hready_i   (s_HREADY),
    .s_hresp_i    (s_HRESP),
    .issue_i      (cpu_issue),
    .cand_valid_o (cpu_cv),
    .cand_o       (cpu_cand),
    .hready_o     (cpu_HREADY),
    .hresp_o      (cpu_HRESP)
  );

  mfp_ahb_input_stage u_ldr_stage (
    .clk_i        (HCLK),
    .rst_i        (HRESET),
    .live_i       (ldr_live),
    .s_hready_i   (s_HREADY),
    .s_hresp_i    (s_HRESP),
    .issue_i      (ldr_issue),
    .cand_valid_o (ldr_cv),
    .cand_o       (ldr_cand),
    .hready_o     (ldr_HREADY),
    .hresp_o      (ldr_HRESP)
  );

  always_comb begin
    win_ldr = ldr_cv;
    if (cpu_cv && ldr_cv) begin
      if ((last_owner_q == MST_LDR) && keeps_grant(ldr_cand)) begin
        win_ldr = MST_LDR;
      end else if ((last_owner_q == MST_CPU) && keeps_grant(cpu_cand)) begin
        win_ldr = MST_CPU;
      end else begin
        win_ldr = LDR_PRIORITY;
      end
    end
  end

  assign any_cand  = cpu_cv || ldr_cv;
  assign win       = win_ldr ? ldr_cand : cpu_cand;
  assign xfer      = s_HREADY && !HRESET && any_cand && win.htrans[1];
  assign cpu_issue = xfer && !win_ldr;
  assign ldr_issue = xfer && win_ldr;

  always_comb begin
    s_HADDR     = cpu_HADDR;
    s_HBURST    = cpu_HBURST;
    s_HPROT     = cpu_HPROT;
    s_HSIZE     = cpu_HSIZE;
    s_HTRANS    = HTRANS_IDLE;
    s_HMASTLOCK = cpu_HMASTLOCK;
    s_HWRITE    = cpu_HWRITE;
    if (any_cand) begin
      s_HADDR     = win.haddr;
      s_HBURST    = win.hburst;
      s_HPROT     = win.hprot;
      s_HSIZE     = win.hsize;
      s_HTRANS    = win.htrans;
      s_HMASTLOCK = win.hmastlock;
      s_HWRITE    = win.hwrite;
    end
    if (HRESET) begin
      s_HTRANS = HTRANS_IDLE;
    end
  end

  assign s_HWDATA  = (dphase_vld_q && (dphase_owner_q == MST_LDR)) ? ldr_HWDATA : cpu_HWDATA;
  assign grant_ldr = (last_owner_q == MST_LDR);

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      last_owner_q   <= MST_CPU;
      dphase_vld_q   <= 1'b0;
      dphase_owner_q <= MST_CPU;
    end else if (s_HREADY) begin
      dphase_vld_q <= xfer;
      if (xfer) begin
        dphase_owner_q <= win_ldr;
      end
      // A BUSY winner also becomes the owner so it keeps the grant for its next beat.
      if (any_cand) begin
        last_owner_q <= win_ldr;
      end
    end
  end

endmodule

// File: tb/tb_mfp_ahb_master_arbiter.sv
// Bench for mfp_ahb_master_arbiter: directed test-plan scenarios, then random traffic
// scored against a transaction-level model of outstanding/held requests per master.
module tb_mfp_ahb_master_arbiter;

  localparam logic [1:0] T_IDLE = 2'b00, T_BUSY = 2'b01, T_NSEQ = 2'b10, T_SEQ = 2'b11;
  localparam bit LDR_PRIO = 1'b1;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic [31:0] cpu_HADDR, ldr_HADDR, cpu_HWDATA, ldr_HWDATA, s_HADDR, s_HWDATA;
  logic [2:0]  cpu_HBURST, ldr_HBURST, cpu_HSIZE, ldr_HSIZE, s_HBURST, s_HSIZE;
  logic [3:0]  cpu_HPROT, ldr_HPROT, s_HPROT;
  logic [1:0]  cpu_HTRANS, ldr_HTRANS, s_HTRANS;
  logic        cpu_HMASTLOCK, ldr_HMASTLOCK, cpu_HWRITE, ldr_HWRITE, s_HMASTLOCK, s_HWRITE;
  logic        cpu_HREADY, ldr_HREADY, cpu_HRESP, ldr_HRESP, s_HREADY, s_HRESP, grant_ldr;

  always #5 HCLK = ~HCLK;

  mfp_ahb_master_arbiter #(.LDR_PRIORITY(LDR_PRIO)) dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .cpu_HADDR(cpu_HADDR), .cpu_HBURST(cpu_HBURST), .cpu_HPROT(cpu_HPROT),
    .cpu_HSIZE(cpu_HSIZE), .cpu_HTRANS(cpu_HTRANS), .cpu_HMASTLOCK(cpu_HMASTLOCK),
    .cpu_HWRITE(cpu_HWRITE), .cpu_HWDATA(cpu_HWDATA), .cpu_HREADY(cpu_HREADY),
    .cpu_HRESP(cpu_HRESP),
    .ldr_HADDR(ldr_HADDR), .ldr_HBURST(ldr_HBURST), .ldr_HPROT(ldr_HPROT),
    .ldr_HSIZE(ldr_HSIZE), .ldr_HTRANS(ldr_HTRANS), .ldr_HMASTLOCK(ldr_HMASTLOCK),
    .ldr_HWRITE(ldr_HWRITE), .ldr_HWDATA(ldr_HWDATA), .ldr_HREADY(ldr_HREADY),
    .ldr_HRESP(ldr_HRESP),
    .s_HADDR(s_HADDR), .s_HBURST(s_HBURST), .s_HPROT(s_HPROT), .s_HSIZE(s_HSIZE),
    .s_HTRANS(s_HTRANS), .s_HMASTLOCK(s_HMASTLOCK), .s_HWRITE(s_HWRITE),
    .s_HWDATA(s_HWDATA), .s_HREADY(s_HREADY), .s_HRESP(s_HRESP), .grant_ldr(grant_ldr)
  );

  typedef struct {
    logic [31:0] addr;
    logic [2:0]  burst;
    logic [3:0]  prot;
    logic [2:0]  size;
    logic [1:0]  trans;
    logic        lock;
    logic        write;
  } req_t;

  int   checks = 0;
  int   errors = 0;
  req_t exp_q[$];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic req_t live_req(int m);
    req_t r;
    if (m == 0) begin
      r.addr = cpu_HADDR; r.burst = cpu_HBURST; r.prot = cpu_HPROT; r.size = cpu_HSIZE;
      r.trans = cpu_HTRANS; r.lock = cpu_HMASTLOCK; r.write = cpu_HWRITE;
    end else begin
      r.addr = ldr_HADDR; r.burst = ldr_HBURST; r.prot = ldr_HPROT; r.size = ldr_HSIZE;
      r.trans = ldr_HTRANS; r.lock = ldr_HMASTLOCK; r.write = ldr_HWRITE;
    end
    return r;
  endfunction

  // Reference model: per master a pending (waiting) request and an outstanding data phase.
  bit   m_on = 1'b0;
  bit   pend [2];
  req_t pend_req [2];
  bit   outst [2];
  bit   last_ldr, dp_vld, dp_ldr;

  always @(negedge HCLK) begin : model
    req_t live [2];
    req_t cand [2];
    bit   rdy [2];
    bit   cv [2];
    bit   acc [2];
    bit   any;
    bit   won_xfer;
    int   w;
    int   own;
    for (int m = 0; m < 2; m++) begin
      live[m] = live_req(m);
      rdy[m]  = pend[m] ? 1'b0 : (outst[m] ? s_HREADY : 1'b1);
    end
    if (m_on) begin
      chk("cpu_HREADY", 32'(cpu_HREADY), 32'(rdy[0]));
      chk("ldr_HREADY", 32'(ldr_HREADY), 32'(rdy[1]));
      chk("cpu_HRESP", 32'(cpu_HRESP), 32'(outst[0] ? s_HRESP : 1'b0));
      chk("ldr_HRESP", 32'(ldr_HRESP), 32'(outst[1] ? s_HRESP : 1'b0));
      chk("grant_ldr", 32'(grant_ldr), 32'(last_ldr));
      if (dp_vld) chk("s_HWDATA", s_HWDATA, dp_ldr ? ldr_HWDATA : cpu_HWDATA);
    end
    if (HRESET) begin
      m_on = 1'b1;
      for (int m = 0; m < 2; m++) begin
        pend[m]  = 1'b0;
        outst[m] = 1'b0;
      end
      last_ldr = 1'b0;
      dp_vld   = 1'b0;
      dp_ldr   = 1'b0;
    end else if (m_on) begin
      for (int m = 0; m < 2; m++) begin
        cv[m]   = pend[m] || (rdy[m] && (live[m].trans != T_IDLE));
        cand[m] = pend[m] ? pend_req[m] : live[m];
        acc[m]  = rdy[m] && (live[m].trans == T_NSEQ || live[m].trans == T_SEQ);
      end
      any = cv[0] || cv[1];
      if (cv[0] && cv[1]) begin
        own = last_ldr ? 1 : 0;
        if (cand[own].trans == T_SEQ || cand[own].trans == T_BUSY || cand[own].lock) w = own;
        else w = LDR_PRIO ? 1 : 0;
      end else begin
        w = cv[1] ? 1 : 0;
      end
      won_xfer = s_HREADY && any && (cand[w].trans == T_NSEQ || cand[w].trans == T_SEQ);
      if (s_HREADY) begin
        outst[0] = 1'b0;
        outst[1] = 1'b0;
        dp_vld   = 1'b0;
        if (any) begin
          exp_q.push_back(cand[w]);
          last_ldr = (w == 1);
          if (won_xfer) begin
            outst[w] = 1'b1;
            pend[w]  = 1'b0;
            dp_vld   = 1'b1;
            dp_ldr   = (w == 1);
          end
        end
      end
      for (int m = 0; m < 2; m++) begin
        if (acc[m] && !(won_xfer && w == m)) begin
          pend[m]     = 1'b1;
          pend_req[m] = live[m];
        end
      end
    end
  end

  // Scoreboard monitor: every address phase the slave accepts must match the next expectation.
  always @(negedge HCLK) begin : monitor
    req_t e;
    #1;
    if (HRESET) begin
      chk("s_HTRANS_reset", 32'(s_HTRANS), 32'(T_IDLE));
    end else if (s_HREADY && s_HTRANS != T_IDLE) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_issue", 32'(s_HTRANS), 32'(T_IDLE));
      end else begin
        e = exp_q.pop_front();
        chk("sb_HADDR", s_HADDR, e.addr);
        chk("sb_HTRANS", 32'(s_HTRANS), 32'(e.trans));
        chk("sb_HWRITE", 32'(s_HWRITE), 32'(e.write));
        chk("sb_HBURST", 32'(s_HBURST), 32'(e.burst));
        chk("sb_HSIZE", 32'(s_HSIZE), 32'(e.size));
        chk("sb_HPROT", 32'(s_HPROT), 32'(e.prot));
        chk("sb_HMASTLOCK", 32'(s_HMASTLOCK), 32'(e.lock));
      end
    end
  end

  task automatic drv(logic rst, logic [1:0] ct, logic [31:0] ca, logic cw,
                     logic [1:0] lt, logic [31:0] la, logic lw, logic sr, logic se);
    @(posedge HCLK);
    #1;
    HRESET = rst;
    cpu_HTRANS = ct; cpu_HADDR = ca; cpu_HWRITE = cw;
    ldr_HTRANS = lt; ldr_HADDR = la; ldr_HWRITE = lw;
    s_HREADY = sr; s_HRESP = se;
    #1;
  endtask

  function automatic logic [1:0] rand_trans();
    int r;
    r = $urandom_range(0, 9);
    if (r < 3) return T_IDLE;
    if (r == 3) return T_BUSY;
    if (r < 7) return T_NSEQ;
    return T_SEQ;
  endfunction

  initial begin
    bit   err2;
    logic rc, rl;
    int   r;
    HRESET = 1'b1;
    cpu_HADDR = 32'h0; ldr_HADDR = 32'h0; cpu_HTRANS = T_NSEQ; ldr_HTRANS = T_NSEQ;
    cpu_HBURST = 3'b000; ldr_HBURST = 3'b000; cpu_HPROT = 4'h3; ldr_HPROT = 4'h3;
    cpu_HSIZE = 3'b010; ldr_HSIZE = 3'b010; cpu_HMASTLOCK = 1'b0; ldr_HMASTLOCK = 1'b0;
    cpu_HWRITE = 1'b0; ldr_HWRITE = 1'b0;
    cpu_HWDATA = 32'hC0DE0000; ldr_HWDATA = 32'h10AD0100;
    s_HREADY = 1'b1; s_HRESP = 1'b0;

    // Reset held for two cycles with both masters requesting.
    drv(1, T_NSEQ, 32'h10, 0, T_NSEQ, 32'h20, 0, 1, 0);
    drv(1, T_NSEQ, 32'h10, 0, T_NSEQ, 32'h20, 0, 1, 0);
    chk("rst_cpu_HREADY", 32'(cpu_HREADY), 32'd1);
    chk("rst_ldr_HREADY", 32'(ldr_HREADY), 32'd1);
    chk("rst_s_HTRANS", 32'(s_HTRANS), 32'(T_IDLE));
    chk("rst_grant_ldr", 32'(grant_ldr), 32'd0);

    // CPU alone: zero added latency.
    drv(0, T_NSEQ, 32'h1FC00000, 0, T_IDLE, 32'h0, 0, 1, 0);
    chk("solo_s_HADDR", s_HADDR, 32'h1FC00000);
    chk("solo_s_HTRANS", 32'(s_HTRANS), 32'(T_NSEQ));
    drv(0, T_IDLE, 32'h0, 0, T_IDLE, 32'h0, 0, 1, 0);
    chk("solo_cpu_HREADY", 32'(cpu_HREADY), 32'd1);
    chk("solo_ldr_HREADY", 32'(ldr_HREADY), 32'd1);

    // Simultaneous writes: LDR first, CPU issued next cycle from its hold register.
    drv(0, T_NSEQ, 32'h0, 1, T_NSEQ, 32'h100, 1, 1, 0);
    chk("sim_t_s_HADDR", s_HADDR, 32'h100);
    drv(0, T_IDLE, 32'h0, 0, T_IDLE, 32'h0, 0, 1, 0);
    chk("sim_t1_cpu_HREADY", 32'(cpu_HREADY), 32'd0);
    chk("sim_t1_s_HADDR", s_HADDR, 32'h0);
    chk("sim_t1_s_HWRITE", 32'(s_HWRITE), 32'd1);
    drv(0, T_IDLE, 32'h0, 0, T_IDLE, 32'h0, 0, 1, 0);
    chk("sim_t2_s_HWDATA", s_HWDATA, 32'hC0DE0000);
    drv(0, T_IDLE, 32'h0, 0, T_IDLE, 32'h0, 0, 1, 0);

    // CPU INCR4 is not interrupted by a higher-priority LDR request.
    cpu_HBURST = 3'b011;
    drv(0, T_NSEQ, 32'h80000000, 0, T_IDLE, 32'h0, 0, 1, 0);
    chk("burst_b1", s_HADDR, 32'h80000000);
    drv(0, T_SEQ, 32'h80000004, 0, T_NSEQ, 32'h200, 0, 1, 0);
    chk("burst_b2", s_HADDR, 32'h80000004);
    drv(0, T_SEQ, 32'h80000008, 0, T_IDLE, 32'h0, 0, 1, 0);
    chk("burst_b3", s_HADDR, 32'h80000008);
    chk("burst_ldr_held", 32'(ldr_HREADY), 32'd0);
    drv(0, T_SEQ, 32'h8000000C, 0, T_IDLE, 32'h0, 0, 1, 0);
    chk("burst_b4", s_HADDR, 32'h8000000C);
    cpu_HBURST = 3'b000;
    drv(0, T_IDLE, 32'h0, 0, T_IDLE, 32'h0, 0, 1, 0);
    chk("burst_ldr_issue", s_HADDR, 32'h200);
    chk("burst_grant_pre", 32'(grant_ldr), 32'd0);
    drv(0, T_IDLE, 32'h0, 0, T_IDLE, 32'h0, 0, 1, 0);
    chk("burst_grant_post", 32'(grant_ldr), 32'd1);

    // Two wait states then ERROR on an LDR write, CPU request held meanwhile.
    drv(0, T_IDLE, 32'h0, 0, T_NSEQ, 32'h300, 1, 1, 0);
    drv(0, T_NSEQ, 32'h400, 0, T_IDLE, 32'h0, 0, 0, 0);
    chk("err_w1_rdy", 32'(ldr_HREADY), 32'd0);
    chk("err_w1_resp", 32'(ldr_HRESP), 32'd0);
    drv(0, T_IDLE, 32'h0, 0, T_IDLE, 32'h0, 0, 0, 0);
    chk("err_w2_rdy", 32'(ldr_HREADY), 32'd0);
    chk("err_cpu_wait", 32'(cpu_HREADY), 32'd0);
    drv(0, T_IDLE, 32'h0, 0, T_IDLE, 32'h0, 0, 0, 1);
    chk("err_e1_rdy", 32'(ldr_HREADY), 32'd0);
    chk("err_e1_resp", 32'(ldr_HRESP), 32'd1);
    chk("err_e1_cpu_resp", 32'(cpu_HRESP), 32'd0);
    drv(0, T_IDLE, 32'h0, 0, T_IDLE, 32'h0, 0, 1, 1);
    chk("err_e2_rdy", 32'(ldr_HREADY), 32'd1);
    chk("err_e2_resp", 32'(ldr_HRESP), 32'd1);
    chk("err_e2_cpu_resp", 32'(cpu_HRESP), 32'd0);
    chk("err_cpu_issue", s_HADDR, 32'h400);
    drv(0, T_IDLE, 32'h0, 0, T_IDLE, 32'h0, 0, 1, 0);

    // Reset while CPU is held and LDR is in its data phase.
    drv(0, T_NSEQ, 32'h500, 0, T_NSEQ, 32'h600, 0, 1, 0);
    drv(1, T_IDLE, 32'h0, 0, T_IDLE, 32'h0, 0, 0, 0);
    chk("mrst_s_HTRANS", 32'(s_HTRANS), 32'(T_IDLE));
    drv(0, T_IDLE, 32'h0, 0, T_IDLE, 32'h0, 0, 1, 0);
    chk("mrst_cpu_HREADY", 32'(cpu_HREADY), 32'd1);
    chk("mrst_ldr_HREADY", 32'(ldr_HREADY), 32'd1);
    chk("mrst_s_HTRANS_after", 32'(s_HTRANS), 32'(T_IDLE));

    // Random traffic: masters only change their request when their own HREADY was high.
    err2 = 1'b0;
    for (int n = 0; n < 1500; n++) begin
      rc = cpu_HREADY;
      rl = ldr_HREADY;
      @(posedge HCLK);
      #1;
      HRESET = ($urandom_range(0, 199) == 0);
      if (rc) begin
        cpu_HTRANS = rand_trans(); cpu_HADDR = $urandom & 32'hFFFF_FFFC;
        cpu_HWRITE = 1'($urandom); cpu_HWDATA = $urandom;
        cpu_HBURST = 3'($urandom); cpu_HSIZE = 3'($urandom); cpu_HPROT = 4'($urandom);
        cpu_HMASTLOCK = ($urandom_range(0, 15) == 0);
      end
      if (rl) begin
        ldr_HTRANS = rand_trans(); ldr_HADDR = $urandom & 32'hFFFF_FFFC;
        ldr_HWRITE = 1'($urandom); ldr_HWDATA = $urandom;
        ldr_HBURST = 3'($urandom); ldr_HSIZE = 3'($urandom); ldr_HPROT = 4'($urandom);
        ldr_HMASTLOCK = ($urandom_range(0, 15) == 0);
      end
      if (err2) begin
        s_HREADY = 1'b1; s_HRESP = 1'b1; err2 = 1'b0;
      end else begin
        r = $urandom_range(0, 19);
        if (r < 4) begin
          s_HREADY = 1'b0; s_HRESP = 1'b0;
        end else if (r == 4) begin
          s_HREADY = 1'b0; s_HRESP = 1'b1; err2 = 1'b1;
        end else begin
          s_HREADY = 1'b1; s_HRESP = 1'b0;
        end
      end
      #2;
    end
    if (err2) drv(0, T_IDLE, 32'h0, 0, T_IDLE, 32'h0, 0, 1, 1);

    cpu_HMASTLOCK = 1'b0;
    ldr_HMASTLOCK = 1'b0;
    for (int n = 0; n < 5; n++) drv(0, T_IDLE, 32'h0, 0, T_IDLE, 32'h0, 0, 1, 0);
    @(negedge HCLK);
    #2;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
